// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with parity/framing/break detection and a FWFT receive FIFO
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rxd,
  input  logic                          rx_en,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          rx_break,
  output logic                          overrun,
  input  logic                          err_clear
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_BIT = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PAR       = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic                 sync1, sync2, rxd_prev;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 all_zero;

  logic                 stop_tick;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 wr_ok;
  logic                 drop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;

  // Third flop only feeds start-edge detection; sampling uses sync2.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= uart_rxd;
      sync2    <= sync1;
      rxd_prev <= sync2;
    end
  end

  assign stop_tick = (state == S_STOP) && (cnt == FULL_BIT);
  assign push      = stop_tick && sync2 && !par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      all_zero   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      rx_break   <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      rx_break   <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rxd_prev && !sync2 && rx_en) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == HALF_BIT) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            all_zero <= 1'b1;
            state    <= sync2 ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == FULL_BIT) begin
            cnt      <= '0;
            shreg    <= {sync2, shreg[DATA_BITS-1:1]};
            all_zero <= all_zero & ~sync2;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= (PARITY != 0) ? S_PAR : S_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (cnt == FULL_BIT) begin
            cnt      <= '0;
            all_zero <= all_zero & ~sync2;
            // Odd parity wants the XOR of data and parity bit to be 1, even wants 0.
            par_bad  <= (^shreg) ^ sync2 ^ (PARITY == 1);
            state    <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == FULL_BIT) begin
            cnt <= '0;
            if (!sync2) begin
              rx_break  <= all_zero;
              frame_err <= !all_zero;
              state     <= S_WAIT_HIGH;
            end else begin
              parity_err <= par_bad;
              state      <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          cnt <= '0;
          if (sync2) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign m_valid    = (count != '0);
  assign full       = (count == DEPTH_C);
  assign pop        = m_valid && m_ready;
  assign wr_ok      = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign m_data     = mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as err_clear leaves overrun set.
      if (drop) begin
        overrun <= 1'b1;
      end else if (err_clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo (8N1 and 8E1 instances, depth 4)
module tb_uart_rx_fifo;

  localparam int CPB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       rxd0 = 1'b1, rx_en0 = 1'b1, m_ready0 = 1'b0, err_clear0 = 1'b0;
  logic [7:0] m_data0;
  logic       m_valid0, fe0, pe0, brk0, ovr0;
  logic [2:0] fifo_count0;
  logic       rxd2 = 1'b1, rx_en2 = 1'b1, m_ready2 = 1'b1, err_clear2 = 1'b0;
  logic [7:0] m_data2;
  logic       m_valid2, fe2, pe2, brk2, ovr2;
  logic [2:0] fifo_count2;

  uart_rx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .uart_rxd(rxd0), .rx_en(rx_en0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready0), .fifo_count(fifo_count0), .frame_err(fe0), .parity_err(pe0),
    .rx_break(brk0), .overrun(ovr0), .err_clear(err_clear0));

  uart_rx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .uart_rxd(rxd2), .rx_en(rx_en2), .m_data(m_data2), .m_valid(m_valid2),
    .m_ready(m_ready2), .fifo_count(fifo_count2), .frame_err(fe2), .parity_err(pe2),
    .rx_break(brk2), .overrun(ovr2), .err_clear(err_clear2));

  int n_cmp = 0;
  int n_fail = 0;

  // Event log: popped words and error-pulse cycles, counted per DUT.
  logic [7:0] pops0[$];
  logic [7:0] pops2[$];
  int n_fe0 = 0, n_pe0 = 0, n_brk0 = 0, n_fe2 = 0, n_pe2 = 0, n_brk2 = 0, n_excl = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid0 && m_ready0) pops0.push_back(m_data0);
      if (m_valid2 && m_ready2) pops2.push_back(m_data2);
      n_fe0  = n_fe0 + int'(fe0);
      n_pe0  = n_pe0 + int'(pe0);
      n_brk0 = n_brk0 + int'(brk0);
      n_fe2  = n_fe2 + int'(fe2);
      n_pe2  = n_pe2 + int'(pe2);
      n_brk2 = n_brk2 + int'(brk2);
      if (int'(fe0) + int'(pe0) + int'(brk0) > 1) n_excl = n_excl + 1;
      if (int'(fe2) + int'(pe2) + int'(brk2) > 1) n_excl = n_excl + 1;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         kind;   // 0 good frame, 1 frame error, 2 break
  } vec_t;

  vec_t       vt[7];
  int         bp, bfe, bpe, bbrk;
  logic [7:0] expq[$];
  logic [7:0] b;
  int         n;

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rxd0 = v;
    else rxd2 = v;
  endtask

  task automatic drive(input int sel, input logic v);
    set_line(sel, v);
    tick(CPB);
  endtask

  // par < 0 means no parity bit; en_off >= 0 drops rx_en0 at that data bit.
  task automatic send(input int sel, input logic [7:0] d, input int par, input logic stop, input int en_off);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == en_off) rx_en0 = 1'b0;
      drive(sel, d[i]);
    end
    if (par >= 0) drive(sel, par[0]);
    drive(sel, stop);
    set_line(sel, 1'b1);
    tick(20);
    if (en_off >= 0) rx_en0 = 1'b1;
  endtask

  task automatic snap0();
    bp = pops0.size(); bfe = n_fe0; bpe = n_pe0; bbrk = n_brk0;
  endtask

  initial begin
    vt[0] = '{8'hA5, 1'b1, 0};
    vt[1] = '{8'h5A, 1'b1, 0};
    vt[2] = '{8'h00, 1'b1, 0};
    vt[3] = '{8'hFF, 1'b1, 0};
    vt[4] = '{8'h7E, 1'b0, 1};
    vt[5] = '{8'h00, 1'b0, 2};
    vt[6] = '{8'h80, 1'b0, 1};

    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_m_valid", int'(m_valid0), 0);
    check("rst_count", int'(fifo_count0), 0);
    check("rst_m_data", int'(m_data0), 0);
    check("rst_overrun", int'(ovr0), 0);
    check("rst_errs", int'(fe0) + int'(pe0) + int'(brk0), 0);
    check("rst_m_valid2", int'(m_valid2), 0);

    m_ready0 = 1'b1;
    foreach (vt[i]) begin
      snap0();
      send(0, vt[i].data, -1, vt[i].stop, -1);
      check($sformatf("vec%0d_pops", i), pops0.size() - bp, (vt[i].kind == 0) ? 1 : 0);
      if (vt[i].kind == 0 && pops0.size() > bp) check($sformatf("vec%0d_data", i), int'(pops0[bp]), int'(vt[i].data));
      check($sformatf("vec%0d_frame_err", i), n_fe0 - bfe, (vt[i].kind == 1) ? 1 : 0);
      check($sformatf("vec%0d_break", i), n_brk0 - bbrk, (vt[i].kind == 2) ? 1 : 0);
      check($sformatf("vec%0d_parity_err", i), n_pe0 - bpe, 0);
      check($sformatf("vec%0d_count", i), int'(fifo_count0), 0);
    end

    // Parity (even): good then bad
    bp = pops2.size(); bpe = n_pe2;
    send(2, 8'h03, 0, 1'b1, -1);
    send(2, 8'h03, 1, 1'b1, -1);
    check("par_pops", pops2.size() - bp, 1);
    if (pops2.size() > bp) check("par_data", int'(pops2[bp]), 3);
    check("par_err", n_pe2 - bpe, 1);
    check("par_count", int'(fifo_count2), 0);
    check("par_fe", n_fe2 + n_brk2, 0);

    // Long break, then a normal frame
    snap0();
    rxd0 = 1'b0;
    tick(15 * CPB);
    rxd0 = 1'b1;
    tick(20);
    check("brk_pulse", n_brk0 - bbrk, 1);
    check("brk_pops", pops0.size() - bp, 0);
    check("brk_fe", n_fe0 - bfe, 0);
    snap0();
    send(0, 8'h5A, -1, 1'b1, -1);
    check("after_brk_pops", pops0.size() - bp, 1);
    if (pops0.size() > bp) check("after_brk_data", int'(pops0[bp]), 8'h5A);

    // Short glitch in idle
    snap0();
    rxd0 = 1'b0;
    tick(3);
    rxd0 = 1'b1;
    tick(3 * CPB);
    check("glitch_pops", pops0.size() - bp, 0);
    check("glitch_flags", (n_fe0 - bfe) + (n_brk0 - bbrk) + (n_pe0 - bpe), 0);

    // rx_en dropped mid-frame still completes the frame
    snap0();
    send(0, 8'h69, -1, 1'b1, 3);
    check("en_mid_pops", pops0.size() - bp, 1);
    if (pops0.size() > bp) check("en_mid_data", int'(pops0[bp]), 8'h69);

    // Overrun with consumer stalled
    m_ready0 = 1'b0;
    for (int k = 0; k < 5; k++) send(0, 8'h11 + 8'(k), -1, 1'b1, -1);
    check("ovr_count", int'(fifo_count0), 4);
    check("ovr_flag", int'(ovr0), 1);
    check("ovr_head", int'(m_data0), 8'h11);
    check("ovr_valid", int'(m_valid0), 1);
    bp = pops0.size();
    m_ready0 = 1'b1;
    tick(10);
    check("ovr_pops", pops0.size() - bp, 4);
    for (int k = 0; k < 4; k++) if (pops0.size() > bp + k) check($sformatf("ovr_pop%0d", k), int'(pops0[bp + k]), 8'h11 + k);
    check("ovr_sticky", int'(ovr0), 1);
    err_clear0 = 1'b1;
    tick(1);
    err_clear0 = 1'b0;
    check("ovr_cleared", int'(ovr0), 0);

    // Reset mid-frame discards FIFO contents and the frame in flight
    m_ready0 = 1'b0;
    send(0, 8'h42, -1, 1'b1, -1);
    check("pre_rst_count", int'(fifo_count0), 1);
    b = 8'h96;
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, b[i]);
    rxd0 = b[4];
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rxd0 = 1'b1;
    tick(40);
    check("mid_rst_count", int'(fifo_count0), 0);
    check("mid_rst_valid", int'(m_valid0), 0);
    m_ready0 = 1'b1;
    snap0();
    send(0, 8'hC3, -1, 1'b1, -1);
    check("post_rst_pops", pops0.size() - bp, 1);
    if (pops0.size() > bp) check("post_rst_data", int'(pops0[bp]), 8'hC3);
    snap0();
    rx_en0 = 1'b0;
    send(0, 8'h33, -1, 1'b1, -1);
    rx_en0 = 1'b1;
    check("rx_en_off_pops", pops0.size() - bp, 0);

    // Randomised bursts against a bounded-queue model
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 6);
      expq.delete();
      m_ready0 = 1'b0;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        if (expq.size() < 4) expq.push_back(b);
        send(0, b, -1, 1'b1, -1);
      end
      check($sformatf("rnd%0d_count", it), int'(fifo_count0), expq.size());
      check($sformatf("rnd%0d_ovr", it), int'(ovr0), (n > 4) ? 1 : 0);
      bp = pops0.size();
      m_ready0 = 1'b1;
      tick(10);
      check($sformatf("rnd%0d_npops", it), pops0.size() - bp, expq.size());
      for (int k = 0; k < expq.size(); k++)
        if (pops0.size() > bp + k) check($sformatf("rnd%0d_pop%0d", it, k), int'(pops0[bp + k]), int'(expq[k]));
      err_clear0 = 1'b1;
      tick(1);
      err_clear0 = 1'b0;
      check($sformatf("rnd%0d_clear", it), int'(ovr0), 0);
    end

    check("pulse_exclusive", n_excl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
